// File: rtl/ram.sv
// Single-port synchronous RAM: write-first, registered read data, synchronous clear.
// Optional per-word even parity with a registered parity_err output when RAM_PARITY_EN is defined.
module ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
`ifdef RAM_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] dout_q, dout_d;

  // A write cycle returns the incoming data, a read cycle returns the stored word.
  always_comb begin
    dout_d = dout_q;
    if (we) begin
      dout_d = data_in;
    end else begin
      dout_d = mem_q[address];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q  <= '{default: '0};
      dout_q <= '0;
    end else begin
      if (we) begin
        mem_q[address] <= data_in;
      end
      dout_q <= dout_d;
    end
  end

  assign data_out = dout_q;

`ifdef RAM_PARITY_EN
  logic par_q [DEPTH];
  logic perr_q, perr_d;

  // Stored parity is compared against a fresh XOR of the stored word on reads.
  always_comb begin
    perr_d = 1'b0;
    if (!we) begin
      perr_d = par_q[address] ^ (^mem_q[address]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      par_q  <= '{default: 1'b0};
      perr_q <= 1'b0;
    end else begin
      if (we) begin
        par_q[address] <= ^data_in;
      end
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_ram.sv
// Directed self-checking bench for ram: reset, write-first, reads, aliasing,
// reset priority, turnaround, and parity checks when RAM_PARITY_EN is defined.
module tb_ram;

  logic       clk;
  logic       reset;
  logic       we;
  logic [1:0] address;
  logic [7:0] data_in;
  logic [7:0] data_out;
`ifdef RAM_PARITY_EN
  logic       parity_err;
`endif

  int n_checks;
  int n_fail;

  ram #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .address  (address),
    .data_in  (data_in),
    .data_out (data_out)
`ifdef RAM_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wider addresses are truncated to the port width, as an external driver would.
  task automatic do_write(input int addr, input logic [7:0] d, input string tag);
    logic [31:0] wide;
    wide    = addr;
    we      = 1'b1;
    address = wide[1:0];
    data_in = d;
    step();
    check(tag, data_out, d);
  endtask

  task automatic do_read(input int addr, input logic [7:0] exp, input string tag);
    logic [31:0] wide;
    wide    = addr;
    we      = 1'b0;
    address = wide[1:0];
    data_in = 8'hEE;
    step();
    check(tag, data_out, exp);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    we       = 1'b1;
    address  = 2'd2;
    data_in  = 8'h55;
    step();
    step();
    check("rst_dout", data_out, 8'h00);
    reset = 1'b0;

    do_read(0, 8'h00, "rst_rd0");
    do_read(1, 8'h00, "rst_rd1");
    do_read(2, 8'h00, "rst_rd2");
    do_read(3, 8'h00, "rst_rd3");

    do_write(0, 8'hAA, "wr0");
    do_write(1, 8'hBB, "wr1");
    do_write(2, 8'hCC, "wr2");
    do_write(3, 8'hAA, "wr3");
    do_read(0, 8'hAA, "rd0");
    do_read(1, 8'hBB, "rd1");
    do_read(2, 8'hCC, "rd2");
    do_read(3, 8'hAA, "rd3");

    do_write(4, 8'hBB, "wr_alias4");
    do_write(5, 8'hCC, "wr_alias5");
    do_read(0, 8'hBB, "alias_rd0");
    do_read(1, 8'hCC, "alias_rd1");
    do_read(2, 8'hCC, "alias_rd2");
    do_read(3, 8'hAA, "alias_rd3");

    do_write(3, 8'h11, "b2b_wr_a");
    do_write(3, 8'h22, "b2b_wr_b");
    do_read(3, 8'h22, "b2b_rd");

    reset   = 1'b1;
    we      = 1'b1;
    address = 2'd2;
    data_in = 8'h55;
    step();
    check("rstpri_dout", data_out, 8'h00);
    reset = 1'b0;
    do_read(2, 8'h00, "rstpri_rd2");
    do_read(0, 8'h00, "rstpri_rd0");
    do_read(3, 8'h00, "rstpri_rd3");

    do_write(1, 8'h3C, "turn_wr");
    do_read(1, 8'h3C, "turn_rd");
    for (int i = 0; i < 3; i++) begin
      step();
      check("turn_hold", data_out, 8'h3C);
    end

`ifdef RAM_PARITY_EN
    do_write(0, 8'hAA, "par_wr");
    check("par_wr_err", {7'd0, parity_err}, 8'h00);
    do_read(0, 8'hAA, "par_rd");
    check("par_ok", {7'd0, parity_err}, 8'h00);
    dut.par_q[0] = ~dut.par_q[0];
    do_read(0, 8'hAA, "par_rd_bad");
    check("par_bad", {7'd0, parity_err}, 8'h01);
    do_write(2, 8'h07, "par_wr2");
    check("par_wr_clr", {7'd0, parity_err}, 8'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
